muldiv_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit with architectural HI/LO registers; companion to the single-cycle ALU in the EX stage.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and MTHI/MTLO in one cycle.
- Uses a valid/ready handshake so the hazard unit stalls dependent MFHI/MFLO while the unit is busy.

---
 rtl/muldiv_unit_pkg.sv | 21 ++
 rtl/muldiv_unit_cond_negate.sv | 12 +
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared op-code and FSM state definitions for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_e;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fix-up.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic             i_Neg,
  input  logic [WIDTH-1:0] i_D,
  output logic [WIDTH-1:0] o
);

  assign o = i_Neg ? -i_D : i_D;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU (one bit per cycle) plus single-cycle MTHI/MTLO on HI/LO.
// Optional MULDIV_EARLY_DONE_EN: zero multiply operands or zero divisor skip the CALC phase.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  input  logic                 i_Valid,
  output logic                 o_Ready,
  input  logic [2:0]           i_Op,
  input  logic [WORD_SIZE-1:0] i_A,
  input  logic [WORD_SIZE-1:0] i_B,
  input  logic                 i_Flush,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic [WORD_SIZE-1:0] o_HI,
  output logic [WORD_SIZE-1:0] o_LO
);

  localparam int W     = WORD_SIZE;
  localparam int CNT_W = $clog2(WORD_SIZE) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic             bzero_q, bzero_d, done_q, done_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [2*W-1:0]   acc_q, acc_d;

  logic             accept, sgn_op, a_neg, b_neg, early;
  logic [W-1:0]     a_mag, b_mag, quo_fix, rem_fix;
  logic [2*W-1:0]   prod_fix, mul_next, div_next;
  logic [W:0]       mul_sum, div_shift, div_diff;

  assign o_Ready = (state_q == S_IDLE);
  assign o_Busy  = ~o_Ready;
  assign o_Done  = done_q;
  assign o_HI    = hi_q;
  assign o_LO    = lo_q;

  assign accept = i_Valid & o_Ready & ~i_Flush;
  assign sgn_op = op_is_signed(i_Op);
  assign a_neg  = sgn_op & i_A[W-1];
  assign b_neg  = sgn_op & i_B[W-1];

  cond_negate #(.WIDTH(W))   u_mag_a    (.i_Neg(a_neg),  .i_D(i_A),              .o(a_mag));
  cond_negate #(.WIDTH(W))   u_mag_b    (.i_Neg(b_neg),  .i_D(i_B),              .o(b_mag));
  cond_negate #(.WIDTH(2*W)) u_fix_prod (.i_Neg(qneg_q), .i_D(acc_q),            .o(prod_fix));
  cond_negate #(.WIDTH(W))   u_fix_quo  (.i_Neg(qneg_q), .i_D(acc_q[W-1:0]),     .o(quo_fix));
  cond_negate #(.WIDTH(W))   u_fix_rem  (.i_Neg(rneg_q), .i_D(acc_q[2*W-1:W]),   .o(rem_fix));

`ifdef MULDIV_EARLY_DONE_EN
  assign early = i_Op[1] ? (i_B == '0) : ((i_A == '0) | (i_B == '0));
`else
  assign early = 1'b0;
`endif

  // acc holds {HI,LO} partial product for multiply, {remainder,quotient} for divide
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? m_q : '0)};
  assign mul_next  = {mul_sum, acc_q[W-1:1]};
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_next  = div_diff[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                 : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!i_Op[2]) begin
            div_d   = i_Op[1];
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            bzero_d = (i_B == '0);
            m_d     = i_Op[1] ? b_mag : a_mag;
            if (early) begin
              // Dividend magnitude preloaded as remainder so a zero divisor yields HI = A
              state_d = S_FIXUP;
              cnt_d   = '0;
              acc_d   = i_Op[1] ? {a_mag, {W{1'b0}}} : '0;
            end else begin
              state_d = S_CALC;
              cnt_d   = CNT_W'(W);
              acc_d   = {{W{1'b0}}, (i_Op[1] ? a_mag : b_mag)};
            end
          end else if (i_Op == OP_MTHI) begin
            hi_d   = i_A;
            done_d = 1'b1;
          end else if (i_Op == OP_MTLO) begin
            lo_d   = i_A;
            done_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        if (i_Flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = div_q ? div_next : mul_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        state_d = S_IDLE;
        if (!i_Flush) begin
          done_d = 1'b1;
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = bzero_q ? '1 : quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge i_CLK) begin
    acc_q <= acc_d;
    m_q   <= m_d;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (honours MULDIV_EARLY_DONE_EN for zero-operand latency).
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;
  localparam int LAT = 34;
`ifdef MULDIV_EARLY_DONE_EN
  localparam int LAT_Z = 2;
`else
  localparam int LAT_Z = 34;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0;
  logic [2:0]   op = 3'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, busy, done;
  logic [W-1:0] hi, lo;
  int total = 0, bad = 0;

  muldiv_unit #(.WORD_SIZE(W)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_Valid(valid), .o_Ready(ready), .i_Op(op),
    .i_A(a), .i_B(b), .i_Flush(flush), .o_Busy(busy), .o_Done(done), .o_HI(hi), .o_LO(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
  endtask

  // Returns in the cycle o_Done is seen; lat counts cycles after the accept edge (-1 on timeout).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output bit rdy_low);
    issue(o, x, y);
    lat = -1; rdy_low = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (done === 1'b1) begin lat = k; break; end
      if (ready !== 1'b0) rdy_low = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    #3;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_mult();
    int lat; bit rl;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000007, lat, rl);
    total++; if (lat != LAT) begin bad++; $display("FAIL mult_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (!rl) begin bad++; $display("FAIL mult_ready_low got=0 exp=1"); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h exp=FFFFFFFF", hi); end
    total++; if (lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_lo got=%h exp=FFFFFFEB", lo); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
    run_op(OP_MULT, 32'h80000000, 32'h80000000, lat, rl);
    total++; if ({hi, lo} !== 64'h40000000_00000000) begin bad++; $display("FAIL mult_min_min got=%h exp=4000000000000000", {hi, lo}); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat; bit rl;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rl);
    total++; if (lat != LAT) begin bad++; $display("FAIL multu_latency got=%0d exp=%0d", lat, LAT); end
    total++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin bad++; $display("FAIL multu_prod got=%h exp=FFFFFFFE00000001", {hi, lo}); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", ready); end
    issue(OP_MTHI, 32'h12345678, 32'h0);
    total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL b2b_mthi_hi got=%h exp=12345678", hi); end
    total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL b2b_mthi_lo got=%h exp=00000001", lo); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_mthi_done got=%b exp=1", done); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_clear got=%b exp=0", done); end
  endtask

  task automatic test_div();
    int lat; bit rl;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, lat, rl);
    total++; if (lat != LAT) begin bad++; $display("FAIL div_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg_lo got=%h exp=FFFFFFFD", lo); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg_hi got=%h exp=FFFFFFFF", hi); end
    step();
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, rl);
    total++; if ({hi, lo} !== 64'h00000000_80000000) begin bad++; $display("FAIL div_ovf got=%h exp=0000000080000000", {hi, lo}); end
    step();
    run_op(OP_DIV, 32'h00000007, 32'hFFFFFFFE, lat, rl);
    total++; if ({hi, lo} !== 64'h00000001_FFFFFFFD) begin bad++; $display("FAIL div_negb got=%h exp=00000001FFFFFFFD", {hi, lo}); end
    step();
    run_op(OP_DIVU, 32'd100, 32'd7, lat, rl);
    total++; if ({hi, lo} !== 64'h00000002_0000000E) begin bad++; $display("FAIL divu_100_7 got=%h exp=000000020000000E", {hi, lo}); end
    step();
  endtask

  task automatic test_zero_ops();
    int lat; bit rl;
    run_op(OP_DIVU, 32'h7, 32'h0, lat, rl);
    total++; if (lat != LAT_Z) begin bad++; $display("FAIL divu_zero_latency got=%0d exp=%0d", lat, LAT_Z); end
    total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_zero_lo got=%h exp=FFFFFFFF", lo); end
    total++; if (hi !== 32'h00000007) begin bad++; $display("FAIL divu_zero_hi got=%h exp=00000007", hi); end
    step();
    run_op(OP_DIV, 32'hFFFFFFFB, 32'h0, lat, rl);
    total++; if ({hi, lo} !== 64'hFFFFFFFB_FFFFFFFF) begin bad++; $display("FAIL div_zero_neg got=%h exp=FFFFFFFBFFFFFFFF", {hi, lo}); end
    step();
    run_op(OP_MULTU, 32'h0, 32'h00012345, lat, rl);
    total++; if (lat != LAT_Z) begin bad++; $display("FAIL multu_zero_latency got=%0d exp=%0d", lat, LAT_Z); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL multu_zero got=%h exp=0000000000000000", {hi, lo}); end
    step();
  endtask

  task automatic test_flush();
    bit saw_done;
    issue(OP_MTHI, 32'hAAAA5555, 32'h0);
    issue(OP_MTLO, 32'h0F0F0F0F, 32'h0);
    total++; if ({hi, lo} !== 64'hAAAA5555_0F0F0F0F) begin bad++; $display("FAIL flush_preload got=%h exp=AAAA55550F0F0F0F", {hi, lo}); end
    issue(OP_DIVU, 32'd100, 32'd7);
    for (int k = 0; k < 9; k++) step();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL flush_busy_before got=%b exp=0", ready); end
    flush = 1'b1; step(); flush = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", ready); end
    total++; if ({hi, lo} !== 64'hAAAA5555_0F0F0F0F) begin bad++; $display("FAIL flush_hilo got=%h exp=AAAA55550F0F0F0F", {hi, lo}); end
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done !== 1'b0) saw_done = 1'b1;
      step();
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL flush_no_done got=%b exp=0", saw_done); end
    op = OP_MTHI; a = 32'hDEADBEEF; valid = 1'b1; flush = 1'b1;
    step();
    valid = 1'b0; flush = 1'b0;
    total++; if (hi !== 32'hAAAA5555) begin bad++; $display("FAIL flush_mthi_blocked got=%h exp=AAAA5555", hi); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_mthi_done got=%b exp=0", done); end
    op = OP_MULT; a = 32'h3; b = 32'h5; valid = 1'b1; flush = 1'b1;
    step();
    valid = 1'b0; flush = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL flush_mult_blocked got=%b exp=1", ready); end
  endtask

  task automatic test_reset_mid();
    int lat; bit rl;
    issue(OP_MTHI, 32'h11111111, 32'h0);
    issue(OP_MTLO, 32'h22222222, 32'h0);
    total++; if ({hi, lo} !== 64'h11111111_22222222) begin bad++; $display("FAIL rstmid_preload got=%h exp=1111111122222222", {hi, lo}); end
    issue(OP_MULT, 32'h3, 32'h5);
    for (int k = 0; k < 4; k++) step();
    #2 rst_n = 1'b0;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL rstmid_hilo got=%h exp=0000000000000000", {hi, lo}); end
    @(negedge clk); rst_n = 1'b1;
    step();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_idle got=%b exp=1", ready); end
    run_op(OP_MULTU, 32'd6, 32'd7, lat, rl);
    total++; if (lat != LAT) begin bad++; $display("FAIL rstmid_after_latency got=%0d exp=%0d", lat, LAT); end
    total++; if ({hi, lo} !== 64'h00000000_0000002A) begin bad++; $display("FAIL rstmid_after_prod got=%h exp=000000000000002A", {hi, lo}); end
    step();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_zero_ops();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
